// File: rtl/uart_regif_arbiter.sv
// rtl/uart_regif_arbiter.sv - two-requester round-robin arbiter for the UART register-file port
//
// Purpose:
//   Shares one register-file memory port between requester 0 (APB bridge)
//   and requester 1 (debug/DMA). The winning command is latched and held on
//   the downstream port until mack_i. The response is routed back to the
//   granted requester. A watchdog forces an error completion when mack_i
//   never arrives.
//
// Ports:
//   clk_i     in   1                 clock
//   arst_i    in   1                 asynchronous active-high reset
//   req_i     in   2                 per-requester request
//   addr_i    in   2*ADDR_WIDTH      requester n address at [n*ADDR_WIDTH +: ADDR_WIDTH]
//   we_i      in   2                 per-requester write enable
//   wdata_i   in   2*DATA_WIDTH      requester n write data, packed like addr_i
//   strb_i    in   2*(DATA_WIDTH/8)  requester n byte strobe, packed like addr_i
//   ack_o     out  2                 per-requester one-cycle acknowledge
//   rdata_o   out  DATA_WIDTH        read data, zero unless an ack_o bit is set
//   resp_o    out  1                 error flag, zero unless an ack_o bit is set
//   mreq_o    out  1                 downstream request
//   maddr_o   out  ADDR_WIDTH        downstream address (latched)
//   mwe_o     out  1                 downstream write enable (latched)
//   mwdata_o  out  DATA_WIDTH        downstream write data (latched)
//   mstrb_o   out  DATA_WIDTH/8      downstream byte strobe (latched)
//   mack_i    in   1                 downstream acknowledge
//   mrdata_i  in   DATA_WIDTH        downstream read data
//   mresp_i   in   1                 downstream error

module uart_regif_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic [1:0]                  req_i,
  input  logic [2*ADDR_WIDTH-1:0]     addr_i,
  input  logic [1:0]                  we_i,
  input  logic [2*DATA_WIDTH-1:0]     wdata_i,
  input  logic [2*(DATA_WIDTH/8)-1:0] strb_i,
  output logic [1:0]                  ack_o,
  output logic [DATA_WIDTH-1:0]       rdata_o,
  output logic                        resp_o,
  output logic                        mreq_o,
  output logic [ADDR_WIDTH-1:0]       maddr_o,
  output logic                        mwe_o,
  output logic [DATA_WIDTH-1:0]       mwdata_o,
  output logic [DATA_WIDTH/8-1:0]     mstrb_o,
  input  logic                        mack_i,
  input  logic [DATA_WIDTH-1:0]       mrdata_i,
  input  logic                        mresp_i
);

  localparam int STRB_W = DATA_WIDTH / 8;

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CNT_MAX_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_MAX_I[CNT_W-1:0];
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // State and latched command.
  state_t              r_state;
  logic                r_ptr;
  logic                r_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]   r_strb;
  logic [CNT_W-1:0]    r_cnt;

  // Next-state decode.
  state_t              w_state_nxt;
  logic                w_grant_en;
  logic                w_win;
  logic                w_timeout;

  // Fields of the winning requester, selected before latching.
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic                w_win_we;
  logic [DATA_WIDTH-1:0] w_win_wdata;
  logic [STRB_W-1:0]   w_win_strb;

  assign w_win_addr  = w_win ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
  assign w_win_we    = w_win ? we_i[1] : we_i[0];
  assign w_win_wdata = w_win ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
  assign w_win_strb  = w_win ? strb_i[2*STRB_W-1:STRB_W] : strb_i[STRB_W-1:0];

  // Watchdog expiry; only meaningful while BUSY.
  assign w_timeout = WD_EN && (r_cnt == CNT_MAX);

  // State register and datapath latches.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_grant <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_en) begin
        r_addr  <= w_win_addr;
        r_we    <= w_win_we;
        r_wdata <= w_win_wdata;
        r_strb  <= w_win_strb;
        r_grant <= w_win;
        // Loser of this grant gets priority on the next tie.
        r_ptr   <= ~w_win;
        r_cnt   <= '0;
      end else if ((r_state == ST_BUSY) && WD_EN && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a request
  // still held during its own ack cycle is never reissued.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_win       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_i != 2'b00) begin
          w_grant_en  = 1'b1;
          w_state_nxt = ST_BUSY;
          if (req_i == 2'b11) begin
            w_win = r_ptr;
          end else begin
            w_win = req_i[1];
          end
        end
      end
      ST_BUSY: begin
        if (mack_i || w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic. The downstream command comes only from the latches, and
  // the response path is zero outside an ack cycle.
  always_comb begin
    mreq_o   = 1'b0;
    maddr_o  = r_addr;
    mwe_o    = r_we;
    mwdata_o = r_wdata;
    mstrb_o  = r_strb;
    ack_o    = 2'b00;
    rdata_o  = '0;
    resp_o   = 1'b0;
    if (r_state == ST_BUSY) begin
      mreq_o = 1'b1;
      if (mack_i) begin
        ack_o   = r_grant ? 2'b10 : 2'b01;
        rdata_o = mrdata_i;
        resp_o  = mresp_i;
      end else if (w_timeout) begin
        ack_o   = r_grant ? 2'b10 : 2'b01;
        resp_o  = 1'b1;
      end
    end
  end

endmodule
